// File: rtl/iir_biquad_seq_pkg.sv
// Shared definitions for the sequential Direct Form I biquad: FSM encoding,
// default widths and saturation bounds derived from the sample width.
package iir_biquad_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_OUT  = 3'd6
    } state_t;

    localparam int DW_DEF    = 4;
    localparam int ACC_W_DEF = 10;
    localparam int SHIFT_DEF = 2;

    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

    localparam int SAT_MAX_DEF = (1 << (DW_DEF - 1)) - 1;
    localparam int SAT_MIN_DEF = -(1 << (DW_DEF - 1));

endpackage

// File: rtl/iir_biquad_seq_smul_s4.sv
// Combinational two's-complement DW x DW multiplier with a full 2*DW product.
module smul_s4 #(
    parameter int DW = 4
) (
    input  logic signed [DW-1:0]   i_a,
    input  logic signed [DW-1:0]   i_b,
    output logic signed [2*DW-1:0] o_p
);

    // Operands are widened first so the product is formed at full width.
    assign o_p = (2*DW)'(i_a) * (2*DW)'(i_b);

endmodule

// File: rtl/iir_biquad_seq.sv
// Second-order IIR section (Direct Form I) that time-shares one signed multiplier
// over five cycles per sample, with valid/ready on both sides.
module iir_biquad_seq
    import iir_biquad_seq_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x_in,
    input  logic signed [DW-1:0] b0,
    input  logic signed [DW-1:0] b1,
    input  logic signed [DW-1:0] b2,
    input  logic signed [DW-1:0] a1,
    input  logic signed [DW-1:0] a2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] y_out,
    output logic                 sat
);

    localparam logic signed [ACC_W-1:0] LP_SAT_MAX = ACC_W'(sat_max(DW));
    localparam logic signed [ACC_W-1:0] LP_SAT_MIN = ACC_W'(sat_min(DW));

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic signed [DW-1:0]    r_y_out;
    logic                    r_sat;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [DW-1:0]    r_x, r_x1, r_x2, r_y1, r_y2;
    logic signed [DW-1:0]    r_b0, r_b1, r_b2, r_a1, r_a2;

    logic signed [DW-1:0]    w_op_coef;
    logic signed [DW-1:0]    w_op_data;
    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_q;

    function automatic logic signed [DW-1:0] f_clip(input logic signed [ACC_W-1:0] q);
        if (q > LP_SAT_MAX)
            f_clip = LP_SAT_MAX[DW-1:0];
        else if (q < LP_SAT_MIN)
            f_clip = LP_SAT_MIN[DW-1:0];
        else
            f_clip = q[DW-1:0];
    endfunction

    function automatic logic f_is_sat(input logic signed [ACC_W-1:0] q);
        return (q > LP_SAT_MAX) || (q < LP_SAT_MIN);
    endfunction

    always_comb begin
        w_op_coef = '0;
        w_op_data = '0;
        case (r_state)
            ST_T0: begin w_op_coef = r_b0; w_op_data = r_x;  end
            ST_T1: begin w_op_coef = r_b1; w_op_data = r_x1; end
            ST_T2: begin w_op_coef = r_b2; w_op_data = r_x2; end
            ST_T3: begin w_op_coef = r_a1; w_op_data = r_y1; end
            ST_T4: begin w_op_coef = r_a2; w_op_data = r_y2; end
            default: ;
        endcase
    end

    smul_s4 #(.DW(DW)) u_mul (
        .i_a (w_op_coef),
        .i_b (w_op_data),
        .o_p (w_prod)
    );

    // Feedback terms are subtracted; in T4 w_acc_next is the finished sum.
    assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_acc_next = (r_state == ST_T3 || r_state == ST_T4) ? (r_acc - w_prod_ext)
                                                                : (r_acc + w_prod_ext);
    assign w_q        = w_acc_next >>> SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_y_out     <= '0;
            r_sat       <= 1'b0;
            r_acc       <= '0;
            r_x         <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_b2        <= '0;
            r_a1        <= '0;
            r_a2        <= '0;
        end else if (clr) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_y_out     <= '0;
            r_sat       <= 1'b0;
            r_acc       <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_x        <= x_in;
                        r_b0       <= b0;
                        r_b1       <= b1;
                        r_b2       <= b2;
                        r_a1       <= a1;
                        r_a2       <= a2;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_T0;
                    end
                end
                ST_T0: begin r_acc <= w_acc_next; r_state <= ST_T1; end
                ST_T1: begin r_acc <= w_acc_next; r_state <= ST_T2; end
                ST_T2: begin r_acc <= w_acc_next; r_state <= ST_T3; end
                ST_T3: begin r_acc <= w_acc_next; r_state <= ST_T4; end
                ST_T4: begin
                    // The clipped value, not the raw quotient, feeds the recursion.
                    r_acc       <= w_acc_next;
                    r_y_out     <= f_clip(w_q);
                    r_sat       <= f_is_sat(w_q);
                    r_x2        <= r_x1;
                    r_x1        <= r_x;
                    r_y2        <= r_y1;
                    r_y1        <= f_clip(w_q);
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y_out     = r_y_out;
    assign sat       = r_sat;

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Scenario bench for iir_biquad_seq: expected outputs are queued when samples are
// driven and popped when the filter presents a result.
module tb_iir_biquad_seq;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic signed [3:0] x_in;
    logic signed [3:0] b0, b1, b2, a1, a2;
    logic              out_valid;
    logic              out_ready;
    logic signed [3:0] y_out;
    logic              sat;

    typedef struct packed {
        logic signed [3:0] y;
        logic              s;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    iir_biquad_seq #(.DW(4), .ACC_W(10), .SHIFT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .a1        (a1),
        .a2        (a2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (in_ready && out_valid) begin
                errors++;
                $display("FAIL ready_valid_exclusive: in_ready=%b out_valid=%b required not both 1", in_ready, out_valid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic signed [3:0] y, input logic s);
        exp_t e;
        e.y = y;
        e.s = s;
        return e;
    endfunction

    task automatic set_coefs(input logic signed [3:0] c0, c1, c2, c3, c4);
        b0 = c0; b1 = c1; b2 = c2; a1 = c3; a2 = c4;
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    // Presents one sample, then returns at the first negedge where out_valid is high
    // along with the number of cycles since the handshake cycle.
    task automatic do_sample(input logic signed [3:0] xv, input bit scramble,
                             output logic signed [3:0] yv, output logic sv, output int lat);
        int w;
        logic signed [3:0] s0, s1, s2, s3, s4;
        @(negedge clk);
        in_valid = 1'b1;
        x_in = xv;
        w = 0;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        in_valid = 1'b0;
        x_in = 4'($urandom);
        lat = 1;
        s0 = b0; s1 = b1; s2 = b2; s3 = a1; s4 = a2;
        if (scramble) set_coefs(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
        yv = y_out;
        sv = sat;
        if (scramble) set_coefs(s0, s1, s2, s3, s4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x_in = '0;
        set_coefs(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_out !== 4'sd0 || sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b y_out=%0d sat=%b required 1 0 0 0",
                     in_ready, out_valid, y_out, sat);
        end
    endtask

    task automatic test_impulse();
        logic signed [3:0] xs[3] = '{4'sd3, 4'sd0, -4'sd5};
        logic signed [3:0] ys[3] = '{4'sd3, 4'sd0, -4'sd5};
        logic signed [3:0] yv;
        logic sv;
        int lat;
        exp_t e;
        set_coefs(4, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(ys[i], 1'b0));
            do_sample(xs[i], i == 1, yv, sv, lat);
            e = exp_q.pop_front();
            checks++;
            if (yv !== e.y || sv !== e.s) begin
                errors++;
                $display("FAIL impulse_y[%0d]: got y=%0d sat=%b required y=%0d sat=%b", i, yv, sv, e.y, e.s);
            end
            checks++;
            if (lat != 6) begin
                errors++;
                $display("FAIL impulse_latency[%0d]: got %0d cycles required 6", i, lat);
            end
        end
    endtask

    task automatic test_feedback();
        logic signed [3:0] xs[4] = '{4'sd4, 4'sd0, 4'sd0, 4'sd0};
        logic signed [3:0] ys[4] = '{4'sd4, 4'sd2, 4'sd1, 4'sd0};
        logic signed [3:0] yv;
        logic sv;
        int lat;
        exp_t e;
        pulse_clr();
        set_coefs(4, 0, 0, -2, 0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(ys[i], 1'b0));
            do_sample(xs[i], 1'b0, yv, sv, lat);
            e = exp_q.pop_front();
            checks++;
            if (yv !== e.y || sv !== e.s) begin
                errors++;
                $display("FAIL feedback_y[%0d]: got y=%0d sat=%b required y=%0d sat=%b", i, yv, sv, e.y, e.s);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [3:0] yv;
        logic sv;
        int lat;
        exp_t e;
        pulse_clr();
        set_coefs(7, 7, 7, 0, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(4'sd7, 1'b1));
            do_sample(4'sd7, i == 2, yv, sv, lat);
            e = exp_q.pop_front();
            checks++;
            if (yv !== e.y || sv !== e.s) begin
                errors++;
                $display("FAIL sat_pos[%0d]: got y=%0d sat=%b required y=%0d sat=%b", i, yv, sv, e.y, e.s);
            end
        end
        pulse_clr();
        set_coefs(7, 0, 0, 0, 0);
        exp_q.push_back(mk(-4'sd8, 1'b1));
        do_sample(-4'sd8, 1'b0, yv, sv, lat);
        e = exp_q.pop_front();
        checks++;
        if (yv !== e.y || sv !== e.s) begin
            errors++;
            $display("FAIL sat_neg: got y=%0d sat=%b required y=%0d sat=%b", yv, sv, e.y, e.s);
        end
    endtask

    task automatic test_backpressure();
        logic signed [3:0] yv;
        logic sv;
        int lat;
        int bad;
        exp_t e;
        pulse_clr();
        set_coefs(4, 0, 0, 0, 0);
        out_ready = 1'b0;
        exp_q.push_back(mk(4'sd5, 1'b0));
        do_sample(4'sd5, 1'b0, yv, sv, lat);
        e = exp_q.pop_front();
        checks++;
        if (yv !== e.y || sv !== e.s) begin
            errors++;
            $display("FAIL bp_y: got y=%0d sat=%b required y=%0d sat=%b", yv, sv, e.y, e.s);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || y_out !== e.y || sat !== e.s) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d of 10 cycles unstable (last out_valid=%b in_ready=%b y=%0d) required 1 0 %0d",
                     bad, out_valid, in_ready, y_out, e.y);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    // Starts a sample that is aborted by clr (use_rst=0) or rst_n (use_rst=1),
    // then checks that a new impulse sees an empty history.
    task automatic test_abort(input bit use_rst);
        logic signed [3:0] yv;
        logic sv;
        int lat;
        int seen;
        exp_t e;
        set_coefs(4, 0, 0, -2, 0);
        @(negedge clk);
        in_valid = 1'b1;
        x_in = 4'sd5;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (!use_rst) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
        end else begin
            @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_out !== 4'sd0 || sat !== 1'b0) begin
                errors++;
                $display("FAIL rst_async: got in_ready=%b out_valid=%b y=%0d sat=%b required 1 0 0 0",
                         in_ready, out_valid, y_out, sat);
            end
            @(negedge clk);
            rst_n = 1'b1;
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle[%0d]: got in_ready=%b out_valid=%b required 1 0", use_rst, in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_output[%0d]: got %0d valid cycles required 0", use_rst, seen);
        end
        exp_q.push_back(mk(4'sd3, 1'b0));
        exp_q.push_back(mk(4'sd1, 1'b0));
        for (int i = 0; i < 2; i++) begin
            do_sample(i == 0 ? 4'sd3 : 4'sd0, 1'b0, yv, sv, lat);
            e = exp_q.pop_front();
            checks++;
            if (yv !== e.y || sv !== e.s) begin
                errors++;
                $display("FAIL abort_y[%0d][%0d]: got y=%0d sat=%b required y=%0d sat=%b",
                         use_rst, i, yv, sv, e.y, e.s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_feedback();
        test_saturation();
        test_backpressure();
        test_abort(1'b0);
        test_abort(1'b1);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
